// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO stream reader: default widths and the
// two-entry output buffer occupancy encoding.
package fifo_pkg;

  localparam int DSIZE_DEF  = 8;
  localparam int CWIDTH_DEF = 16;
  localparam int OCC_W      = 2;

  typedef logic [OCC_W-1:0] occ_t;

  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bundles the synchronous-FIFO read side and the downstream valid/ready stream.
// The reader uses the master view; the FIFO and sink environment uses the slave view.
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) ();

  logic             fifo_empty;
  logic [DSIZE-1:0] fifo_dout;
  logic             fifo_rd_en;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry in-order output buffer: head holds the oldest word and drives the
// downstream data register directly; tail holds the second word when full.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output occ_t             occ,
  output logic             valid,
  output logic [DSIZE-1:0] head
);

  occ_state_e       state;
  occ_state_e       state_next;
  logic [DSIZE-1:0] tail;
  logic [DSIZE-1:0] head_next;
  logic [DSIZE-1:0] tail_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= OCC_EMPTY;
      head  <= '0;
      tail  <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      head  <= head_next;
      tail  <= tail_next;
      valid <= (state_next != OCC_EMPTY);
    end
  end

  // Push while full without a pop cannot happen: the reader never requests more
  // words than the buffer can absorb.
  always_comb begin
    state_next = state;
    head_next  = head;
    tail_next  = tail;
    if (flush) begin
      state_next = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (push) begin
            head_next  = push_data;
            state_next = OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({push, pop})
            2'b11: head_next = push_data;
            2'b10: begin
              tail_next  = push_data;
              state_next = OCC_FULL;
            end
            2'b01: state_next = OCC_EMPTY;
            default: ;
          endcase
        end
        OCC_FULL: begin
          if (pop) begin
            head_next = tail;
            if (push) tail_next = push_data;
            else      state_next = OCC_ONE;
          end
        end
        default: state_next = OCC_EMPTY;
      endcase
    end
  end

  assign occ = occ_t'(state);

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (one-cycle read latency) into a valid/ready stream
// at up to one word per cycle, counting delivered words.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DSIZE  = DSIZE_DEF,
  parameter int CWIDTH = CWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  fifo_stream_reader_if.master bus,
  output logic [CWIDTH-1:0] rd_count
);

  logic             run;
  logic             infl;
  logic             push;
  logic             xfer;
  logic             rd_en;
  occ_t             occ;
  logic [OCC_W:0]   level;
  logic             buf_valid;
  logic [DSIZE-1:0] buf_data;

  // run holds off reads until the first rising edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run      <= 1'b0;
      infl     <= 1'b0;
      rd_count <= '0;
    end else begin
      run  <= 1'b1;
      infl <= rd_en;
      if (xfer) rd_count <= rd_count + CWIDTH'(1);
    end
  end

  assign xfer  = buf_valid & bus.m_ready;
  assign push  = infl & ~flush;
  // Words the buffer will hold once this cycle's transfer and capture settle.
  assign level = {1'b0, occ} + {{OCC_W{1'b0}}, infl} - {{OCC_W{1'b0}}, xfer};
  assign rd_en = run & ~bus.fifo_empty & ~flush & (level < (OCC_W+1)'(2));

  stream_skid_buf #(
    .DSIZE (DSIZE)
  ) u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (bus.fifo_dout),
    .pop       (xfer),
    .flush     (flush),
    .occ       (occ),
    .valid     (buf_valid),
    .head      (buf_data)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = buf_valid;
  assign bus.m_data     = buf_data;

endmodule
